riscv_mc_ctrl: RTL and testbench
================================

# riscv_mc_ctrl

Multi-cycle main control sequencer for the RISC-V RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the PC, instruction-register, register-file and memory enables, and generates the immediate-type select that steers the immediate generator's five outputs (I/S/B/U/J) into the ALU and PC-target paths. It also counts retired instructions.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction-register output; valid from DECODE until the next FETCH.
- `imem_ready`  in  1  instruction fetch complete this cycle.
- `dmem_ready`  in  1  data access complete this cycle.
- `branch_taken`  in  1  ALU compare result; sampled in EXEC only.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  load the instruction register.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (stores).
- `pc_we`  out  1  update the PC.
- `pc_src`  out  2  PC source: 0=PC+4, 1=PC+imm, 2=ALU result with bit 0 cleared.
- `imm_sel`  out  3  immediate select: 0=I, 1=S, 2=B, 3=U, 4=J.
- `alu_src_a`  out  1  ALU A operand: 0=rs1, 1=PC.
- `alu_src_b`  out  1  ALU B operand: 0=rs2, 1=imm.
- `rf_we`  out  1  register-file write.
- `wb_sel`  out  2  writeback source: 0=ALU, 1=mem data, 2=PC+4, 3=imm_u.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `illegal`  out  1  sticky flag: unsupported opcode decoded.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- State encoding: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH.
- FETCH
  - `imem_req`=1, held until `imem_ready`.
  - On `imem_ready`: `ir_we`=1 for that cycle only, then go to DECODE.
  - `imem_ready` is ignored when `imem_req`=0.
- DECODE: one cycle. Classify `instr[6:0]`.
  - Opcodes outside {0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP} go to TRAP.
  - All other opcodes go to EXEC.
- EXEC: one cycle.
  - BRANCH: `pc_we`=1, `pc_src`=`branch_taken`?1:0, `retire`, then FETCH.
  - LOAD, STORE: go to MEM.
  - All other legal opcodes: go to WB.
- MEM
  - `dmem_req`=1 until `dmem_ready`; `dmem_we`=1 for STORE only.
  - On ready, STORE: `pc_we`=1, `pc_src`=0, `retire`, then FETCH.
  - On ready, LOAD: go to WB.
- WB: one cycle. `rf_we`=1, `pc_we`=1, `retire`, then FETCH.
  - JAL: `pc_src`=1, `wb_sel`=2.
  - JALR: `pc_src`=2, `wb_sel`=2.
  - LOAD: `pc_src`=0, `wb_sel`=1.
  - LUI: `pc_src`=0, `wb_sel`=3.
  - All others: `pc_src`=0, `wb_sel`=0.
- Decode fields in DECODE/EXEC/MEM/WB:
  - `imm_sel`: I for OP-IMM/LOAD/JALR; S for STORE; B for BRANCH; U for LUI/AUIPC; J for JAL.
  - `alu_src_a`=1 for AUIPC/JAL/BRANCH-target, else 0.
  - `alu_src_b`=1 for all opcodes except OP and BRANCH.
  - All decode fields are 0 in FETCH and TRAP.
- TRAP
  - `illegal`=1, held until reset.
  - No requests or enables are issued.
  - The state is absorbing until reset.
- `instret` increments by 1 on each `retire` and wraps modulo 2^CNT_W, from all-ones to 0.
- Strobes (`ir_we`, `pc_we`, `rf_we`, `retire`) never exceed one cycle per instruction.

## Timing
- All outputs are Moore/combinational from the registered state, opcode and ready inputs. No registered output lag.
- While `rst`=1:
  - Every output is 0, `instret`=0 and `illegal`=0.
  - The first cycle after deassertion is FETCH with `imem_req`=1.
- Reset mid-operation (any state): the next state is FETCH. No `pc_we`, `rf_we`, `dmem_req` or `retire` is issued in the reset cycle.
- Cycles per instruction, with zero-wait memories (ready in the request cycle):
  - BRANCH: 3
  - ALU, LUI, AUIPC, JAL, JALR: 4
  - STORE: 4
  - LOAD: 5
- Each memory wait cycle adds 1.
- `branch_taken` and `dmem_ready` arriving in states other than EXEC and MEM respectively have no effect.

## Test plan
- ADDI x1,x0,5 (0x00500093), `imem_ready`=1: 4-cycle sequence FETCH→DECODE→EXEC→WB; `imm_sel`=0, `alu_src_b`=1; in WB `rf_we`=1, `wb_sel`=0, `pc_src`=0; `instret` goes 0→1.
- BEQ (0x00000463) with `branch_taken`=1 in EXEC: `imm_sel`=2, `pc_we`=1, `pc_src`=1, no `rf_we`; repeated with `branch_taken`=0: `pc_src`=0.
- LW (0x0000A103), `dmem_ready` low for 2 cycles: `dmem_req` high for 3 cycles with `dmem_we`=0; WB has `wb_sel`=1; total 7 cycles.
- JALR (0x000080E7): WB has `pc_src`=2, `wb_sel`=2, `rf_we`=1. SW (0x0020A023): `imm_sel`=1, `dmem_we`=1, no `rf_we`.
- Opcode 0x0000007F: TRAP after DECODE; `illegal` stays 1 and `imem_req` stays 0 for 20 cycles; `rst` clears both.
- `rst` pulsed in MEM of a store: no write and no `retire`; next cycle FETCH. Counter preloaded to all-ones: the next `retire` wraps `instret` to 0.

Source files
------------

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for an
// RV32I core. Outputs are decoded combinationally from the state register, the
// latched instruction opcode and the memory ready inputs.
module riscv_mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [2:0]       imm_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMMU = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt_q;
  logic [OPC_W-1:0]   opcode;
  logic               is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic               is_load, is_store, is_opimm, is_op, is_legal;
  logic               in_decode_phase;
  logic               unused_instr_bits;

  // Only the opcode field steers control; the rest of the word feeds the datapath.
  assign unused_instr_bits = ^instr[31:7];

  // Opcode classification from the instruction register
  always_comb begin
    opcode    = instr[6:0];
    is_lui    = (opcode == OPC_LUI);
    is_auipc  = (opcode == OPC_AUIPC);
    is_jal    = (opcode == OPC_JAL);
    is_jalr   = (opcode == OPC_JALR);
    is_branch = (opcode == OPC_BRANCH);
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_opimm  = (opcode == OPC_OPIMM);
    is_op     = (opcode == OPC_OP);
    is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                is_load | is_store | is_opimm | is_op;
  end

  // State sequencing; reset from any state returns to FETCH, TRAP is absorbing
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (imem_ready) state <= S_DECODE;
        S_DECODE: state <= is_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (is_branch)               state <= S_FETCH;
          else if (is_load | is_store) state <= S_MEM;
          else                         state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) state <= is_store ? S_FETCH : S_WB;
        end
        S_WB:     state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instret = rst ? '0 : cnt_q;

  // Control outputs decoded from state, opcode and ready inputs; all quiet in reset
  always_comb begin
    imem_req        = 1'b0;
    ir_we           = 1'b0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    pc_we           = 1'b0;
    pc_src          = PC_PLUS4;
    imm_sel         = IMM_I;
    alu_src_a       = 1'b0;
    alu_src_b       = 1'b0;
    rf_we           = 1'b0;
    wb_sel          = WB_ALU;
    retire          = 1'b0;
    illegal         = 1'b0;
    in_decode_phase = (state == S_DECODE) || (state == S_EXEC) ||
                      (state == S_MEM)    || (state == S_WB);

    if (!rst) begin
      if (in_decode_phase) begin
        if (is_store)                 imm_sel = IMM_S;
        else if (is_branch)           imm_sel = IMM_B;
        else if (is_lui | is_auipc)   imm_sel = IMM_U;
        else if (is_jal)              imm_sel = IMM_J;
        else                          imm_sel = IMM_I;
        alu_src_a = is_auipc | is_jal | is_branch;
        alu_src_b = ~(is_op | is_branch);
      end

      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          if (is_branch) begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? PC_IMM : PC_PLUS4;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ready && is_store) begin
            pc_we  = 1'b1;
            pc_src = PC_PLUS4;
            retire = 1'b1;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          if (is_jal) begin
            pc_src = PC_IMM;
            wb_sel = WB_PC4;
          end else if (is_jalr) begin
            pc_src = PC_ALU;
            wb_sel = WB_PC4;
          end else if (is_load) begin
            wb_sel = WB_MEM;
          end else if (is_lui) begin
            wb_sel = WB_IMMU;
          end
        end
        S_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: each driven cycle queues its hand-computed
// output vector; a negedge monitor pops and compares against the DUT.
module tb_riscv_mc_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          imem_ready, dmem_ready, branch_taken;
  logic          imem_req, ir_we, dmem_req, dmem_we, pc_we;
  logic [1:0]    pc_src;
  logic [2:0]    imm_sel;
  logic          alu_src_a, alu_src_b, rf_we;
  logic [1:0]    wb_sel;
  logic          retire, illegal;
  logic [CW-1:0] instret;

  riscv_mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rf_we(rf_we),
    .wb_sel(wb_sel), .retire(retire), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, ir_we, dmem_req, dmem_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic       alu_src_a, alu_src_b, rf_we;
    logic [1:0] wb_sel;
    logic       retire, illegal;
  } exp_t;

  typedef struct {
    string         nm;
    exp_t          e;
    logic [CW-1:0] cnt;
  } sb_t;

  sb_t           sbq[$];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] mcnt  = '0;

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] BEQ   = 32'h00000463;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] JALR  = 32'h000080E7;
  localparam logic [31:0] SW    = 32'h0020A023;
  localparam logic [31:0] JAL   = 32'h0000006F;
  localparam logic [31:0] LUI   = 32'h000000B7;
  localparam logic [31:0] AUIPC = 32'h00000097;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] BAD   = 32'h0000007F;

  function automatic exp_t ev(bit rq, bit iw, bit dq, bit dw, bit pw, bit [1:0] ps,
                              bit [2:0] is, bit a, bit b, bit rw, bit [1:0] ws,
                              bit rt, bit il);
    return {rq, iw, dq, dw, pw, ps, is, a, b, rw, ws, rt, il};
  endfunction

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic cyc(input string nm, input logic [31:0] ins, input logic ir,
                     input logic dr, input logic bt, input logic r, input exp_t e);
    sb_t it;
    instr = ins; imem_ready = ir; dmem_ready = dr; branch_taken = bt; rst = r;
    it.nm  = nm;
    it.e   = e;
    it.cnt = r ? '0 : mcnt;
    sbq.push_back(it);
    if (r) mcnt = '0;
    else if (e.retire) mcnt = mcnt + CW'(1);
    @(posedge clk); #1;
  endtask

  // Monitor: compare DUT outputs with the queued expectation mid-cycle.
  always @(negedge clk) begin : monitor
    sb_t  it;
    exp_t act;
    if (sbq.size() > 0) begin
      it  = sbq.pop_front();
      act = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, imm_sel,
             alu_src_a, alu_src_b, rf_we, wb_sel, retire, illegal};
      tests++;
      if (act !== it.e || instret !== it.cnt) begin
        fails++;
        $display("FAIL %s: got outs=%b instret=%0d, want outs=%b instret=%0d",
                 it.nm, act, instret, it.e, it.cnt);
      end
    end
  end

  exp_t z, fet, fwait;

  initial begin
    z     = ev(0,0,0,0,0,0,0,0,0,0,0,0,0);
    fet   = ev(1,1,0,0,0,0,0,0,0,0,0,0,0);
    fwait = ev(1,0,0,0,0,0,0,0,0,0,0,0,0);
    instr = '0; imem_ready = 0; dmem_ready = 0; branch_taken = 0; rst = 1;
    @(posedge clk); #1;

    // reset with all inputs asserted: every output stays 0
    cyc("rst0", ADDI, 1, 1, 1, 1, z);
    cyc("rst1", SW,   1, 1, 1, 1, z);

    // ADDI with one fetch wait; branch_taken outside EXEC ignored
    cyc("addi_fwait", ADDI, 0, 0, 0, 0, fwait);
    cyc("addi_f",     ADDI, 1, 0, 0, 0, fet);
    cyc("addi_d",     ADDI, 1, 1, 1, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc("addi_e",     ADDI, 1, 1, 1, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc("addi_wb",    ADDI, 1, 1, 0, 0, ev(0,0,0,0,1,0,0,0,1,1,0,1,0));

    // BEQ taken then not taken
    cyc("beqt_f", BEQ, 1, 0, 0, 0, fet);
    cyc("beqt_d", BEQ, 0, 0, 0, 0, ev(0,0,0,0,0,0,2,1,0,0,0,0,0));
    cyc("beqt_e", BEQ, 0, 0, 1, 0, ev(0,0,0,0,1,1,2,1,0,0,0,1,0));
    cyc("beqn_f", BEQ, 1, 0, 0, 0, fet);
    cyc("beqn_d", BEQ, 0, 0, 1, 0, ev(0,0,0,0,0,0,2,1,0,0,0,0,0));
    cyc("beqn_e", BEQ, 0, 0, 0, 0, ev(0,0,0,0,1,0,2,1,0,0,0,1,0));

    // LW with two data wait cycles; dmem_ready before MEM ignored
    cyc("lw_f",  LW, 1, 0, 0, 0, fet);
    cyc("lw_d",  LW, 0, 1, 0, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc("lw_e",  LW, 0, 1, 0, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc("lw_m0", LW, 0, 0, 0, 0, ev(0,0,1,0,0,0,0,0,1,0,0,0,0));
    cyc("lw_m1", LW, 0, 0, 0, 0, ev(0,0,1,0,0,0,0,0,1,0,0,0,0));
    cyc("lw_m2", LW, 0, 1, 0, 0, ev(0,0,1,0,0,0,0,0,1,0,0,0,0));
    cyc("lw_wb", LW, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,0,1,1,1,1,0));

    // JALR
    cyc("jalr_f",  JALR, 1, 0, 0, 0, fet);
    cyc("jalr_d",  JALR, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc("jalr_e",  JALR, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    cyc("jalr_wb", JALR, 0, 0, 0, 0, ev(0,0,0,0,1,2,0,0,1,1,2,1,0));

    // SW zero-wait
    cyc("sw_f", SW, 1, 0, 0, 0, fet);
    cyc("sw_d", SW, 0, 0, 0, 0, ev(0,0,0,0,0,0,1,0,1,0,0,0,0));
    cyc("sw_e", SW, 0, 0, 0, 0, ev(0,0,0,0,0,0,1,0,1,0,0,0,0));
    cyc("sw_m", SW, 0, 1, 0, 0, ev(0,0,1,1,1,0,1,0,1,0,0,1,0));

    // JAL, LUI, AUIPC, OP
    cyc("jal_f",  JAL, 1, 0, 0, 0, fet);
    cyc("jal_d",  JAL, 0, 0, 0, 0, ev(0,0,0,0,0,0,4,1,1,0,0,0,0));
    cyc("jal_e",  JAL, 0, 0, 0, 0, ev(0,0,0,0,0,0,4,1,1,0,0,0,0));
    cyc("jal_wb", JAL, 0, 0, 0, 0, ev(0,0,0,0,1,1,4,1,1,1,2,1,0));
    cyc("lui_f",  LUI, 1, 0, 0, 0, fet);
    cyc("lui_d",  LUI, 0, 0, 0, 0, ev(0,0,0,0,0,0,3,0,1,0,0,0,0));
    cyc("lui_e",  LUI, 0, 0, 0, 0, ev(0,0,0,0,0,0,3,0,1,0,0,0,0));
    cyc("lui_wb", LUI, 0, 0, 0, 0, ev(0,0,0,0,1,0,3,0,1,1,3,1,0));
    cyc("aui_f",  AUIPC, 1, 0, 0, 0, fet);
    cyc("aui_d",  AUIPC, 0, 0, 0, 0, ev(0,0,0,0,0,0,3,1,1,0,0,0,0));
    cyc("aui_e",  AUIPC, 0, 0, 0, 0, ev(0,0,0,0,0,0,3,1,1,0,0,0,0));
    cyc("aui_wb", AUIPC, 0, 0, 0, 0, ev(0,0,0,0,1,0,3,1,1,1,0,1,0));
    cyc("add_f",  ADD, 1, 0, 0, 0, fet);
    cyc("add_d",  ADD, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add_e",  ADD, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("add_wb", ADD, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,0,0,1,0,1,0));

    // reset while a store sits in MEM with dmem_ready high: nothing issued
    cyc("swr_f",   SW, 1, 0, 0, 0, fet);
    cyc("swr_d",   SW, 0, 0, 0, 0, ev(0,0,0,0,0,0,1,0,1,0,0,0,0));
    cyc("swr_e",   SW, 0, 0, 0, 0, ev(0,0,0,0,0,0,1,0,1,0,0,0,0));
    cyc("swr_rst", SW, 0, 1, 0, 1, z);

    // 17 ADDIs: instret climbs to all-ones, wraps to 0, then 1
    for (int i = 0; i < 17; i++) begin
      cyc("wrap_f",  ADDI, 1, 0, 0, 0, fet);
      cyc("wrap_d",  ADDI, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
      cyc("wrap_e",  ADDI, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
      cyc("wrap_wb", ADDI, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,0,1,1,0,1,0));
    end

    // illegal opcode: TRAP is absorbing and quiet until reset
    cyc("bad_f", BAD, 1, 0, 0, 0, fet);
    cyc("bad_d", BAD, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,0,1,0,0,0,0));
    for (int i = 0; i < 20; i++)
      cyc("trap", BAD, 1, 1, 1, 0, ev(0,0,0,0,0,0,0,0,0,0,0,0,1));
    cyc("trap_rst",  BAD,  1, 1, 1, 1, z);
    cyc("post_trap", ADDI, 0, 0, 0, 0, fwait);

    @(negedge clk); #1;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d queued, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
